// File: rtl/fnd_pkg.sv
// Shared constants, FSM encoding and the double-dabble step for the FND scan block.
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int BIN_W      = 14;
    localparam int BCD_TOT_W  = NUM_DIGITS * BCD_W;

    localparam logic [BIN_W-1:0] MAX_VALUE = 14'd9999;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } conv_state_t;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next bit.
    function automatic logic [BCD_TOT_W-1:0] dabble_step(input logic [BCD_TOT_W-1:0] b,
                                                         input logic                 in_bit);
        logic [BCD_TOT_W-1:0] a;
        a = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (a[i*BCD_W +: BCD_W] >= 4'd5)
                a[i*BCD_W +: BCD_W] = a[i*BCD_W +: BCD_W] + 4'd3;
        end
        return {a[BCD_TOT_W-2:0], in_bit};
    endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Serial binary-to-BCD converter. The first shift happens on the start edge, so all
// BIN_W shifts are done after BIN_W-1 further cycles and done pulses for one cycle.
module fnd_bin2bcd
    import fnd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_TOT_W-1:0] bcd
);

    conv_state_t      state;
    logic [BIN_W-1:0] sr;
    logic [3:0]       cnt;

    // Conversion FSM: IDLE -> SHIFT (one bit per cycle) -> IDLE with a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sr    <= '0;
            cnt   <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bcd   <= dabble_step('0, bin[BIN_W-1]);
                        sr    <= {bin[BIN_W-2:0], 1'b0};
                        cnt   <= 4'd1;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd <= dabble_step(bcd, sr[BIN_W-1]);
                    sr  <= {sr[BIN_W-2:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(BIN_W-1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan controller: prescaled digit scan, atomic display update from
// the serial converter, overflow clamp and leading-zero blanking. All outputs registered.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [13:0]      i_value,
    input  logic             i_load,
    input  logic             i_lz_blank,
    output logic             o_busy,
    output logic             o_overflow,
    output logic [1:0]       o_digitSelect,
    output logic [3:0]       o_bcd,
    output logic             o_blank
);

    localparam int              DIV     = CLK_HZ / SCAN_HZ;
    localparam int              PW      = $clog2(DIV);
    localparam logic [PW-1:0]   PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0]                          presc;
    logic                                   tick;
    logic [1:0]                             sel_nxt;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]       disp;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]       disp_nxt;
    logic [NUM_DIGITS-1:0]                  zero_above;
    logic                                   blank_nxt;
    logic                                   ovf_pend;
    logic                                   accept;
    logic                                   commit;
    logic                                   conv_busy;
    logic                                   conv_done;
    logic [BCD_TOT_W-1:0]                   conv_bcd;

    assign accept = i_load & ~o_busy & ~conv_busy;
    assign commit = conv_done & o_busy;

    fnd_bin2bcd u_bin2bcd (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .start (accept),
        .bin   (i_value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Next-state view of scan index and display so a coinciding tick+commit shows new data.
    always_comb begin
        tick     = (presc == PRE_MAX);
        sel_nxt  = tick ? o_digitSelect + 2'd1 : o_digitSelect;
        disp_nxt = disp;
        if (commit)
            disp_nxt = ovf_pend ? {NUM_DIGITS{4'd9}} : conv_bcd;
        zero_above[NUM_DIGITS-1] = (disp_nxt[NUM_DIGITS-1] == '0);
        for (int n = NUM_DIGITS - 2; n >= 0; n--)
            zero_above[n] = zero_above[n+1] & (disp_nxt[n] == '0);
        blank_nxt = i_lz_blank && (sel_nxt != 2'd0) && zero_above[sel_nxt];
    end

    // Prescaler and digit scan counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            presc         <= '0;
            o_digitSelect <= 2'd0;
        end else begin
            presc         <= tick ? '0 : presc + 1'b1;
            o_digitSelect <= sel_nxt;
        end
    end

    // Load handshake, overflow capture and atomic display commit.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            disp       <= '0;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
            ovf_pend   <= 1'b0;
        end else begin
            disp <= disp_nxt;
            if (accept) begin
                o_busy   <= 1'b1;
                ovf_pend <= (i_value > MAX_VALUE);
            end else if (commit) begin
                o_busy     <= 1'b0;
                o_overflow <= ovf_pend;
            end
        end
    end

    // Registered digit code and blank drive.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_bcd   <= 4'd0;
            o_blank <= 1'b1;
        end else begin
            o_bcd   <= disp_nxt[sel_nxt];
            o_blank <= blank_nxt;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller at CLK_HZ=8, SCAN_HZ=2 (four cycles per digit).
module tb_fnd_scan_controller;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [13:0] i_value;
    logic        i_load;
    logic        i_lz_blank;
    logic        o_busy;
    logic        o_overflow;
    logic [1:0]  o_digitSelect;
    logic [3:0]  o_bcd;
    logic        o_blank;

    always #5 i_clk = ~i_clk;

    fnd_scan_controller #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_value       (i_value),
        .i_load        (i_load),
        .i_lz_blank    (i_lz_blank),
        .o_busy        (o_busy),
        .o_overflow    (o_overflow),
        .o_digitSelect (o_digitSelect),
        .o_bcd         (o_bcd),
        .o_blank       (o_blank)
    );

    typedef struct packed {
        logic [15:0] digs;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 9999) begin
            e.digs = 16'h9999;
            e.ovf  = 1'b1;
        end else begin
            e.digs = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf  = 1'b0;
        end
        return e;
    endfunction

    function automatic logic exp_blk(input logic [15:0] digs, input int n, input logic lz);
        logic z;
        z = 1'b1;
        for (int k = n; k < 4; k++)
            if (digs[k*4 +: 4] != 4'd0) z = 1'b0;
        return lz && (n != 0) && z;
    endfunction

    // Sample one full scan (16 cycles) and compare against the next scoreboard entry.
    task automatic check_disp(input string tag);
        logic [15:0] digs;
        logic [3:0]  blk;
        exp_t        e;
        digs = '0;
        blk  = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge i_clk);
            digs[o_digitSelect*4 +: 4] = o_bcd;
            blk[o_digitSelect]         = o_blank;
        end
        chk({tag, "_sb_size"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("%s_d%0d", tag, n), digs[n*4 +: 4], e.digs[n*4 +: 4]);
                chk($sformatf("%s_blank%0d", tag, n), blk[n], exp_blk(e.digs, n, i_lz_blank));
            end
            chk({tag, "_ovf"}, o_overflow, e.ovf);
        end
    endtask

    // Issue a load and measure the busy period; optionally retry loads mid-conversion and on commit.
    task automatic do_load(input string tag, input int v, input bit inj);
        int busy_n;
        int extra;
        @(negedge i_clk);
        i_value = 14'(v);
        i_load  = 1'b1;
        exp_q.push_back(model(v));
        busy_n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            i_load = 1'b0;
            if (!o_busy) break;
            busy_n++;
            if (inj && (c == 5 || c == 14)) begin
                i_load  = 1'b1;
                i_value = 14'd5678;
            end
        end
        i_load = 1'b0;
        chk({tag, "_busy_len"}, busy_n, 14);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_busy) extra++;
        end
        chk({tag, "_no_rebusy"}, extra, 0);
        check_disp(tag);
    endtask

    initial begin
        i_reset_n  = 1'b0;
        i_value    = '0;
        i_load     = 1'b0;
        i_lz_blank = 1'b0;

        // Reset state, held three cycles.
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("rst_sel", o_digitSelect, 0);
            chk("rst_bcd", o_bcd, 0);
            chk("rst_blank", o_blank, 1);
            chk("rst_busy", o_busy, 0);
            chk("rst_ovf", o_overflow, 0);
        end
        i_reset_n = 1'b1;

        // Scan sequence after release: digit advances every fourth edge.
        for (int i = 1; i <= 17; i++) begin
            @(negedge i_clk);
            chk($sformatf("scan_sel_%0d", i), o_digitSelect, (i / 4) % 4);
            if (i == 1) begin
                chk("rel_blank", o_blank, 0);
                chk("rel_bcd", o_bcd, 0);
            end
        end

        do_load("conv1234", 1234, 1'b0);
        do_load("ovf12000", 12000, 1'b0);
        do_load("after_ovf5", 5, 1'b0);

        i_lz_blank = 1'b1;
        do_load("lz7", 7, 1'b0);
        i_lz_blank = 1'b0;
        exp_q.push_back(model(7));
        check_disp("nolz7");

        do_load("ignore", 1234, 1'b1);

        // Reset on cycle 7 of a conversion of 4321: no commit, display cleared.
        @(negedge i_clk);
        i_value = 14'd4321;
        i_load  = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge i_clk);
            i_load = 1'b0;
        end
        i_reset_n = 1'b0;
        exp_q.push_back(model(0));
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        chk("midrst_busy", o_busy, 0);
        begin
            int extra;
            extra = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge i_clk);
                if (o_busy) extra++;
            end
            chk("midrst_no_busy", extra, 0);
        end
        check_disp("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
